// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the 5-stage MIPS core.
//   - ALUOp encodings driven by the main decoder
//   - funct codes examined by the ALU control decoder
//   - ALU control encodings presented to the ALU
//   - bit positions and width of the 9-bit ID/EX control bundle
package mips_pkg;

   // Control bundle: {RegWrite, MemtoReg, MemRead, MemWrite, Branch,
   //                  ALUSrc, RegDst, ALUOp[1:0]}
   localparam int unsigned CTRL_W       = 9;
   localparam int unsigned CTRL_REGWR   = 8;
   localparam int unsigned CTRL_MEM2REG = 7;
   localparam int unsigned CTRL_MEMRD   = 6;
   localparam int unsigned CTRL_MEMWR   = 5;
   localparam int unsigned CTRL_BRANCH  = 4;
   localparam int unsigned CTRL_ALUSRC  = 3;
   localparam int unsigned CTRL_REGDST  = 2;
   localparam int unsigned CTRL_ALUOP_H = 1;
   localparam int unsigned CTRL_ALUOP_L = 0;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10
   } aluop_e;

   typedef enum logic [5:0] {
      FUNCT_ADD = 6'b100000,
      FUNCT_SUB = 6'b100010,
      FUNCT_AND = 6'b100100,
      FUNCT_OR  = 6'b100101,
      FUNCT_NOR = 6'b100111,
      FUNCT_SLT = 6'b101010
   } funct_e;

   typedef enum logic [3:0] {
      ALUCTL_AND = 4'b0000,
      ALUCTL_OR  = 4'b0001,
      ALUCTL_ADD = 4'b0010,
      ALUCTL_SUB = 4'b0110,
      ALUCTL_SLT = 4'b0111,
      ALUCTL_NOR = 4'b1100
   } alu_ctrl_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
//   ex_valid_i, ex_mem_read_i, ex_rt_i : load currently in EX and its target
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   id_uses_rt_i                       : ID instruction reads rt as a source
//   lu_o                               : ID must wait one cycle for the load
module load_use_detect #(
   parameter int unsigned REG_W = 5
) (
   input  logic             ex_valid_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rt_i,
   output logic             lu_o
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rt_i == id_rs_i);
      rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
      // $zero is hardwired, so a load targeting it never creates a dependency
      lu_o     = ex_valid_i & ex_mem_read_i & id_valid_i & (ex_rt_i != '0) &
                 (rs_match | rt_match);
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion,
// branch flush, external stall and saturating bubble/flush counters.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   id_*                  : decoded instruction from ID
//   flush_i               : branch-taken flush (kills the ID instruction)
//   ext_stall_i           : downstream stall, hold everything
//   hazard_stall_o        : combinational freeze request for PC and IF/ID
//   ex_*                  : registered EX-stage view; ALUOp/funct feed ALU control
//   bubble_cnt_o          : load-use bubbles inserted (saturating)
//   flush_cnt_o           : flushes that killed a valid instruction (saturating)
module id_ex_stage_reg
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic [DATA_W-1:0] id_pc4_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_W-1:0]  id_rs_i,
   input  logic [REG_W-1:0]  id_rt_i,
   input  logic [REG_W-1:0]  id_rd_i,
   input  logic              id_uses_rt_i,
   input  logic              flush_i,
   input  logic              ext_stall_i,
   output logic              hazard_stall_o,
   output logic              ex_valid_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [1:0]        ex_alu_op_o,
   output logic [5:0]        ex_funct_o,
   output logic [DATA_W-1:0] ex_pc4_o,
   output logic [DATA_W-1:0] ex_rs_data_o,
   output logic [DATA_W-1:0] ex_rt_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [REG_W-1:0]  ex_rs_o,
   output logic [REG_W-1:0]  ex_rt_o,
   output logic [REG_W-1:0]  ex_rd_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [5:0]        funct;
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } ex_regs_t;

   ex_regs_t         ex_q, ex_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu;

   load_use_detect #(.REG_W(REG_W)) u_lu (
      .ex_valid_i    (ex_q.valid),
      .ex_mem_read_i (ex_q.ctrl[CTRL_MEMRD]),
      .ex_rt_i       (ex_q.rt),
      .id_valid_i    (id_valid_i),
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_uses_rt_i  (id_uses_rt_i),
      .lu_o          (lu)
   );

   always_comb begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      // Flush and ext stall already freeze/redirect the front end themselves
      hazard_stall_o = lu & ~flush_i & ~ext_stall_i;

      if (flush_i) begin
         ex_d = '0;
         if (id_valid_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end else if (ext_stall_i) begin
         // hold: defaults keep every register unchanged
      end else if (lu) begin
         // all-zero bubble: ALUOp=00 (ADD), RegWrite=MemWrite=0
         ex_d = '0;
         if (bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         end
      end else begin
         ex_d.valid   = id_valid_i;
         ex_d.ctrl    = id_valid_i ? id_ctrl_i : '0;
         ex_d.funct   = id_imm_i[5:0];
         ex_d.pc4     = id_pc4_i;
         ex_d.rs_data = id_rs_data_i;
         ex_d.rt_data = id_rt_data_i;
         ex_d.imm     = id_imm_i;
         ex_d.rs      = id_rs_i;
         ex_d.rt      = id_rt_i;
         ex_d.rd      = id_rd_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   always_comb begin
      ex_valid_o   = ex_q.valid;
      ex_ctrl_o    = ex_q.ctrl;
      ex_alu_op_o  = ex_q.ctrl[CTRL_ALUOP_H:CTRL_ALUOP_L];
      ex_funct_o   = ex_q.funct;
      ex_pc4_o     = ex_q.pc4;
      ex_rs_data_o = ex_q.rs_data;
      ex_rt_data_o = ex_q.rt_data;
      ex_imm_o     = ex_q.imm;
      ex_rs_o      = ex_q.rs;
      ex_rt_o      = ex_q.rt;
      ex_rd_o      = ex_q.rd;
      bubble_cnt_o = bubble_cnt_q;
      flush_cnt_o  = flush_cnt_q;
   end

endmodule
